// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit data, strobe and scan outputs of the 7-segment driver
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] hex_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    load;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [IDX_W-1:0]        digit_idx;
  modport master (output hex_in, dp_in, blank_mask, load, input seg_out, dp_out, digit_sel, digit_idx);
  modport slave  (input hex_in, dp_in, blank_mask, load, output seg_out, dp_out, digit_sel, digit_idx);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment scanner with blanking gaps (option SEG7_LEADING_ZERO_BLANK_EN)
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);
  localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX  = CLK_DIV > BLANK_CYCLES ? CLK_DIV : BLANK_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  typedef enum logic {BLANK, DISP} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    dark;
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      4'hF: decode = 7'b0111000;
      default: decode = 7'b1111111;
    endcase
  endfunction
  // next scan position, shadow contents and the outputs they imply
  always_comb begin
    hex_d   = bus.load ? bus.hex_in : hex_q;
    dp_d    = bus.load ? bus.dp_in : dp_q;
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    if (state_q == BLANK && cnt_q == CW'(BLANK_CYCLES - 1)) begin
      cnt_d   = '0;
      state_d = DISP;
      idx_d   = idx_q == IDX_W'(NUM_DIGITS - 1) ? '0 : idx_q + IDX_W'(1);
    end
    if (state_q == DISP && cnt_q == CW'(CLK_DIV - 1)) begin
      cnt_d   = '0;
      state_d = BLANK;
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    dark = bus.blank_mask[idx_d] || (idx_d != '0 && (hex_d >> {idx_d, 2'b00}) == '0);
`else
    dark = bus.blank_mask[idx_d];
`endif
    seg_d = state_d != DISP || dark ? 7'h7f : decode(hex_d[{idx_d, 2'b00} +: 4]);
    dpo_d = state_d != DISP || dark || !dp_d[idx_d];
    sel_d = state_d == DISP ? ~(NUM_DIGITS'(1) << idx_d) : '1;
  end
  // scan FSM, shadow registers and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= IDX_W'(NUM_DIGITS - 1);
      hex_q   <= '0;
      dp_q    <= '0;
      seg_q   <= 7'h7f;
      dpo_q   <= 1'b1;
      sel_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      sel_q   <= sel_d;
    end
  end
  assign bus.seg_out   = seg_q;
  assign bus.dp_out    = dpo_q;
  assign bus.digit_sel = sel_q;
  assign bus.digit_idx = idx_q;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Holds NUM_DIGITS hex nibbles in a shadow register and scans one digit at a time.
- Inserts a programmable all-off blanking gap between digits to suppress ghosting.
- Replaces per-digit static decoders on boards where segment lines are shared across digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8
CLK_DIV, 50000, clock cycles each digit is lit (DISP period); must be >= 2
BLANK_CYCLES, 16, clock cycles of all-off between digits (BLANK period); must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
hex_in  in  4*NUM_DIGITS  digit values; nibble k = hex_in[4k+3:4k]; digit 0 is the least significant
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_mask  in  NUM_DIGITS  1 = force digit k dark (segments and dp off)
load  in  1  1-cycle strobe; latches hex_in and dp_in into the shadow registers
seg_out  out  7  active-low segments, bit 6 = a, bit 0 = g (a..g order, MSB first)
dp_out  out  1  active-low decimal point
digit_sel  out  NUM_DIGITS  active-low one-hot digit enable
digit_idx  out  IDX_W  index of the currently selected digit; IDX_W = max(1, clog2(NUM_DIGITS))

Behaviour:
- Clocking and reset: single clock domain (clk). rst is synchronous, active-high.
- Reset values:
  - state = BLANK, cnt = 0, idx = NUM_DIGITS-1.
  - Shadow hex = 0, shadow dp = 0.
  - seg_out = 7'b1111111, dp_out = 1, digit_sel = all 1s, digit_idx = NUM_DIGITS-1.
- Shadow load: when load = 1 on an edge, the shadow registers take hex_in/dp_in. The new value is visible on outputs from the next edge if the addressed digit is in DISP. blank_mask is not shadowed and is sampled live.
- FSM (2 states, cnt shared):
  - BLANK: digit_sel all 1s, seg_out all 1s, dp_out = 1. cnt increments each cycle. When cnt == BLANK_CYCLES-1: cnt <= 0, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1, state <= DISP.
  - DISP: digit_sel = ~(1 << idx). seg_out = decode(shadow nibble idx). dp_out = ~shadow_dp[idx]. If blank_mask[idx] = 1: seg_out = all 1s and dp_out = 1, while digit_sel still drives. cnt increments each cycle. When cnt == CLK_DIV-1: cnt <= 0, state <= BLANK.
- Outputs are registered: they are computed from next-state values, so they change on the same edge as state and idx. No combinational paths from inputs to outputs.
- Timing:
  - First lit digit after rst deasserts is digit 0, lit for BLANK_CYCLES cycles later.
  - Full frame = NUM_DIGITS*(CLK_DIV+BLANK_CYCLES) cycles.
- Wrap: idx wraps from NUM_DIGITS-1 to 0. For NUM_DIGITS = 1, idx stays 0.
- Decode table (active-low, abcdefg):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
  - Any X/undefined input decodes to 1111111.
- Simultaneous events:
  - load on the same edge as a BLANK->DISP transition: the new shadow value is what gets displayed.
  - rst with load: rst wins, and the shadow registers clear.
- Reset mid-scan: takes effect on the next edge regardless of state or cnt. Outputs go dark on that edge.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - In DISP, digit k (k >= 1) is treated as blanked when shadow nibbles k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - Suppression is ORed with blank_mask.
  - dp is also suppressed for a suppressed digit.
- Undefined: no suppression; all digits show their nibble. Logic must be absent, not merely gated.

Test Plan:
- Reset release (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2), rst held 3 cycles -> digit_sel = 1111 and seg_out = 1111111 during reset and 2 cycles after; then digit_sel = 1110 and digit_idx = 0 for exactly 8 cycles.
- load with hex_in = 16'h1A3F, dp_in = 4'b0100 -> over one frame, seg_out sequence per DISP: F = 0111000, 3 = 0000110, A = 0001000 with dp_out = 0, 1 = 1001111. Frame length = 40 cycles.
- Wrap and blanking: observe digit 3 DISP -> 2 BLANK cycles with digit_sel = 1111 -> digit 0 DISP; no cycle has two digit_sel bits low.
- blank_mask = 4'b0010 with hex 16'h8888 -> digit 1 has digit_sel = 1101 and seg_out = 1111111; the other digits show 0000000.
- rst asserted mid-DISP of digit 2 (cnt = 5) -> next edge all outputs dark and digit_idx = 3; after release, scan restarts at digit 0 with shadow = 0, so seg_out = 0000001.
- SEG7_LEADING_ZERO_BLANK_EN defined, hex = 16'h0050 -> digits 3 and 2 dark, digit 1 = 0100100, digit 0 = 0000001. With the macro undefined, digit 3 = 0000001.
